// File: rtl/rps_pkg.sv
// Shared definitions for the stone-paper-scissors match core.
// Contents:
//   - move codes     : none / rock / paper / scissors (2 bits)
//   - result codes   : draw / p1 wins / p2 wins / no result (2 bits)
//   - rps_state_e    : match sequencer state encoding (3 bits, codes visible on the state port)
//   - rps_beats(a,b) : 1 when move a defeats move b
package rps_pkg;

  localparam logic [1:0] MV_NONE     = 2'b00;
  localparam logic [1:0] MV_ROCK     = 2'b01;
  localparam logic [1:0] MV_PAPER    = 2'b10;
  localparam logic [1:0] MV_SCISSORS = 2'b11;

  localparam logic [1:0] RES_DRAW = 2'b00;
  localparam logic [1:0] RES_P1   = 2'b01;
  localparam logic [1:0] RES_P2   = 2'b10;
  localparam logic [1:0] RES_NONE = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_COLLECT   = 3'd1,
    ST_JUDGE     = 3'd2,
    ST_SHOW      = 3'd3,
    ST_MATCH_END = 3'd4
  } rps_state_e;

  // Rock beats scissors, scissors beats paper, paper beats rock.
  // MV_NONE never beats anything and is never beaten.
  function automatic logic rps_beats(input logic [1:0] a, input logic [1:0] b);
    logic win;
    win = 1'b0;
    if ((a == MV_ROCK) && (b == MV_SCISSORS)) begin
      win = 1'b1;
    end else if ((a == MV_SCISSORS) && (b == MV_PAPER)) begin
      win = 1'b1;
    end else if ((a == MV_PAPER) && (b == MV_ROCK)) begin
      win = 1'b1;
    end else begin
      win = 1'b0;
    end
    return win;
  endfunction

endpackage

// File: rtl/rps_judge.sv
// Combinational round judge.
// Ports:
//   m1_i, m2_i   in  2  registered moves of player 1 / player 2
//   l1_i, l2_i   in  1  player 1 / player 2 holds a committed move
//   result_o     out 2  draw / p1 / p2
// When only one player committed (round timed out) that player wins by forfeit;
// when neither committed the round is a draw.
module rps_judge
  import rps_pkg::*;
(
  input  logic [1:0] m1_i,
  input  logic [1:0] m2_i,
  input  logic       l1_i,
  input  logic       l2_i,
  output logic [1:0] result_o
);

  // Full comparison when both locked, forfeit rules otherwise.
  always_comb begin
    result_o = RES_DRAW;
    if (l1_i && l2_i) begin
      if (rps_beats(m1_i, m2_i)) begin
        result_o = RES_P1;
      end else if (rps_beats(m2_i, m1_i)) begin
        result_o = RES_P2;
      end else begin
        result_o = RES_DRAW;
      end
    end else if (l1_i) begin
      result_o = RES_P1;
    end else if (l2_i) begin
      result_o = RES_P2;
    end else begin
      result_o = RES_DRAW;
    end
  end

endmodule

// File: rtl/rps_match_ctrl.sv
// Match sequencer for the stone-paper-scissors game core: collects one locked move per
// player per round, enforces a round timeout, judges the round, keeps scores and ends a
// best-of-N match.
// Ports:
//   clk_i            in   1  clock, rising edge
//   rst_i            in   1  synchronous reset, active-high
//   start_i          in   1  begin a new match (only in IDLE or MATCH_END)
//   p1_move_i        in   2  player 1 move (00 none, 01 rock, 10 paper, 11 scissors)
//   p1_lock_i        in   1  player 1 commit
//   p2_move_i        in   2  player 2 move
//   p2_lock_i        in   1  player 2 commit
//   state_o          out  3  FSM state code
//   p1_locked_o      out  1  player 1 holds a committed move
//   p2_locked_o      out  1  player 2 holds a committed move
//   round_done_o     out  1  pulse in the first SHOW cycle
//   round_result_o   out  2  00 draw, 01 p1, 10 p2, 11 no result yet
//   p1_score_o       out  4  rounds won by player 1
//   p2_score_o       out  4  rounds won by player 2
//   round_cnt_o      out  4  rounds judged in this match
//   match_done_o     out  1  high while in MATCH_END
//   match_winner_o   out  2  00 draw, 01 p1, 10 p2, 11 undecided
module rps_match_ctrl
  import rps_pkg::*;
#(
  parameter int ROUNDS_TO_WIN  = 2,
  parameter int MAX_ROUNDS     = 9,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int SHOW_CYCLES    = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [1:0] p1_move_i,
  input  logic       p1_lock_i,
  input  logic [1:0] p2_move_i,
  input  logic       p2_lock_i,
  output logic [2:0] state_o,
  output logic       p1_locked_o,
  output logic       p2_locked_o,
  output logic       round_done_o,
  output logic [1:0] round_result_o,
  output logic [3:0] p1_score_o,
  output logic [3:0] p2_score_o,
  output logic [3:0] round_cnt_o,
  output logic       match_done_o,
  output logic [1:0] match_winner_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int SW = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;

  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [SW-1:0] SHOW_LAST = SW'(SHOW_CYCLES - 1);
  localparam logic [3:0]    WIN_SCORE = 4'(ROUNDS_TO_WIN);
  localparam logic [3:0]    LAST_RND  = 4'(MAX_ROUNDS);

  rps_state_e    state_q;
  logic          p1_locked_q;
  logic          p2_locked_q;
  logic [1:0]    p1_move_q;
  logic [1:0]    p2_move_q;
  logic [TW-1:0] tmo_cnt_q;
  logic [SW-1:0] show_cnt_q;
  logic          round_done_q;
  logic [1:0]    round_result_q;
  logic [3:0]    p1_score_q;
  logic [3:0]    p2_score_q;
  logic [3:0]    round_cnt_q;
  logic          match_done_q;
  logic [1:0]    match_winner_q;

  logic          p1_cap;
  logic          p2_cap;
  logic          p1_locked_d;
  logic          p2_locked_d;
  logic [1:0]    p1_move_d;
  logic [1:0]    p2_move_d;
  logic          match_over;
  logic [1:0]    winner_d;
  logic [1:0]    judge_res;

  rps_judge u_judge (
    .m1_i     (p1_move_q),
    .m2_i     (p2_move_q),
    .l1_i     (p1_locked_q),
    .l2_i     (p2_locked_q),
    .result_o (judge_res)
  );

  // First valid lock per player in COLLECT wins; later locks and 00 moves are dropped.
  always_comb begin
    p1_cap      = (state_q == ST_COLLECT) && p1_lock_i && (p1_move_i != MV_NONE) && !p1_locked_q;
    p2_cap      = (state_q == ST_COLLECT) && p2_lock_i && (p2_move_i != MV_NONE) && !p2_locked_q;
    p1_locked_d = p1_locked_q | p1_cap;
    p2_locked_d = p2_locked_q | p2_cap;
    if (p1_cap) begin
      p1_move_d = p1_move_i;
    end else begin
      p1_move_d = p1_move_q;
    end
    if (p2_cap) begin
      p2_move_d = p2_move_i;
    end else begin
      p2_move_d = p2_move_q;
    end
  end

  // Match end check and winner choice, evaluated on already-updated scores in SHOW.
  always_comb begin
    match_over = (p1_score_q == WIN_SCORE) || (p2_score_q == WIN_SCORE) ||
                 (round_cnt_q == LAST_RND);
    winner_d   = RES_DRAW;
    if (p1_score_q == WIN_SCORE) begin
      winner_d = RES_P1;
    end else if (p2_score_q == WIN_SCORE) begin
      winner_d = RES_P2;
    end else if (p1_score_q > p2_score_q) begin
      winner_d = RES_P1;
    end else if (p2_score_q > p1_score_q) begin
      winner_d = RES_P2;
    end else begin
      winner_d = RES_DRAW;
    end
  end

  // Match sequencer FSM with all outputs registered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= ST_IDLE;
      p1_locked_q    <= 1'b0;
      p2_locked_q    <= 1'b0;
      p1_move_q      <= MV_NONE;
      p2_move_q      <= MV_NONE;
      tmo_cnt_q      <= '0;
      show_cnt_q     <= '0;
      round_done_q   <= 1'b0;
      round_result_q <= RES_NONE;
      p1_score_q     <= 4'd0;
      p2_score_q     <= 4'd0;
      round_cnt_q    <= 4'd0;
      match_done_q   <= 1'b0;
      match_winner_q <= RES_NONE;
    end else begin
      round_done_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_MATCH_END: begin
          if (start_i) begin
            state_q        <= ST_COLLECT;
            p1_locked_q    <= 1'b0;
            p2_locked_q    <= 1'b0;
            p1_move_q      <= MV_NONE;
            p2_move_q      <= MV_NONE;
            tmo_cnt_q      <= '0;
            round_result_q <= RES_NONE;
            p1_score_q     <= 4'd0;
            p2_score_q     <= 4'd0;
            round_cnt_q    <= 4'd0;
            match_done_q   <= 1'b0;
            match_winner_q <= RES_NONE;
          end else begin
            state_q <= state_q;
          end
        end
        ST_COLLECT: begin
          p1_locked_q <= p1_locked_d;
          p2_locked_q <= p2_locked_d;
          p1_move_q   <= p1_move_d;
          p2_move_q   <= p2_move_d;
          // Captures on this edge count before the timeout decision.
          if (p1_locked_d && p2_locked_d) begin
            state_q <= ST_JUDGE;
          end else if (tmo_cnt_q == TMO_LAST) begin
            state_q <= ST_JUDGE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
        end
        ST_JUDGE: begin
          round_result_q <= judge_res;
          round_cnt_q    <= round_cnt_q + 4'd1;
          if (judge_res == RES_P1) begin
            p1_score_q <= p1_score_q + 4'd1;
          end else if (judge_res == RES_P2) begin
            p2_score_q <= p2_score_q + 4'd1;
          end else begin
            p1_score_q <= p1_score_q;
          end
          round_done_q <= 1'b1;
          show_cnt_q   <= '0;
          state_q      <= ST_SHOW;
        end
        ST_SHOW: begin
          if (show_cnt_q == SHOW_LAST) begin
            if (match_over) begin
              state_q        <= ST_MATCH_END;
              match_done_q   <= 1'b1;
              match_winner_q <= winner_d;
            end else begin
              state_q     <= ST_COLLECT;
              p1_locked_q <= 1'b0;
              p2_locked_q <= 1'b0;
              p1_move_q   <= MV_NONE;
              p2_move_q   <= MV_NONE;
              tmo_cnt_q   <= '0;
            end
          end else begin
            show_cnt_q <= show_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign state_o        = state_q;
  assign p1_locked_o    = p1_locked_q;
  assign p2_locked_o    = p2_locked_q;
  assign round_done_o   = round_done_q;
  assign round_result_o = round_result_q;
  assign p1_score_o     = p1_score_q;
  assign p2_score_o     = p2_score_q;
  assign round_cnt_o    = round_cnt_q;
  assign match_done_o   = match_done_q;
  assign match_winner_o = match_winner_q;

endmodule

// File: tb/tb_rps_match_ctrl.sv
// Directed bench for rps_match_ctrl with ROUNDS_TO_WIN=2, MAX_ROUNDS=3,
// TIMEOUT_CYCLES=8, SHOW_CYCLES=2.
module tb_rps_match_ctrl;

  localparam logic [1:0] ROCK     = 2'b01;
  localparam logic [1:0] PAPER    = 2'b10;
  localparam logic [1:0] SCISSORS = 2'b11;
  localparam logic [1:0] NONE     = 2'b00;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] p1_move;
  logic       p1_lock;
  logic [1:0] p2_move;
  logic       p2_lock;
  logic [2:0] state;
  logic       p1_locked;
  logic       p2_locked;
  logic       round_done;
  logic [1:0] round_result;
  logic [3:0] p1_score;
  logic [3:0] p2_score;
  logic [3:0] round_cnt;
  logic       match_done;
  logic [1:0] match_winner;

  int checks = 0;
  int errors = 0;

  rps_match_ctrl #(
    .ROUNDS_TO_WIN  (2),
    .MAX_ROUNDS     (3),
    .TIMEOUT_CYCLES (8),
    .SHOW_CYCLES    (2)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .start_i        (start),
    .p1_move_i      (p1_move),
    .p1_lock_i      (p1_lock),
    .p2_move_i      (p2_move),
    .p2_lock_i      (p2_lock),
    .state_o        (state),
    .p1_locked_o    (p1_locked),
    .p2_locked_o    (p2_locked),
    .round_done_o   (round_done),
    .round_result_o (round_result),
    .p1_score_o     (p1_score),
    .p2_score_o     (p2_score),
    .round_cnt_o    (round_cnt),
    .match_done_o   (match_done),
    .match_winner_o (match_winner)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Both players lock in the same cycle; returns in the first SHOW cycle.
  task automatic lock_both(input logic [1:0] m1, input logic [1:0] m2);
    p1_move = m1; p2_move = m2; p1_lock = 1'b1; p2_lock = 1'b1;
    tick(1);
    p1_lock = 1'b0; p2_lock = 1'b0;
    tick(1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    p1_move = NONE; p1_lock = 1'b0; p2_move = NONE; p2_lock = 1'b0;
    tick(2);
    check("rst_state", 4'(state), 4'd0);
    check("rst_result", 4'(round_result), 4'h3);
    check("rst_winner", 4'(match_winner), 4'h3);
    check("rst_mdone", 4'(match_done), 4'd0);
    check("rst_p1score", p1_score, 4'd0);

    // 1. reset in the middle of COLLECT with p1 locked
    rst = 1'b0; start = 1'b1;
    tick(1);
    start = 1'b0;
    check("t1_collect", 4'(state), 4'd1);
    p1_move = ROCK; p1_lock = 1'b1;
    tick(1);
    p1_lock = 1'b0;
    check("t1_p1locked", 4'(p1_locked), 4'd1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("t1_state", 4'(state), 4'd0);
    check("t1_p1locked0", 4'(p1_locked), 4'd0);
    check("t1_score", p1_score, 4'd0);
    check("t1_result", 4'(round_result), 4'h3);

    // 2. same-cycle locks, rock vs scissors
    start = 1'b1;
    tick(1);
    start = 1'b0;
    p1_move = ROCK; p2_move = SCISSORS; p1_lock = 1'b1; p2_lock = 1'b1;
    tick(1);
    p1_lock = 1'b0; p2_lock = 1'b0;
    check("t2_judge", 4'(state), 4'd2);
    tick(1);
    check("t2_show", 4'(state), 4'd3);
    check("t2_rdone", 4'(round_done), 4'd1);
    check("t2_result", 4'(round_result), 4'h1);
    check("t2_p1score", p1_score, 4'd1);
    check("t2_rcnt", round_cnt, 4'd1);
    tick(1);
    check("t2_rdone_pulse", 4'(round_done), 4'd0);
    check("t2_show2", 4'(state), 4'd3);
    tick(1);
    check("t2_back_collect", 4'(state), 4'd1);
    check("t2_locks_clear", 4'(p1_locked), 4'd0);
    check("t2_result_hold", 4'(round_result), 4'h1);

    // 3. p2 wins two rounds
    rst = 1'b1;
    tick(1);
    rst = 1'b0; start = 1'b1;
    tick(1);
    start = 1'b0;
    lock_both(ROCK, PAPER);
    check("t3_r1_result", 4'(round_result), 4'h2);
    check("t3_r1_p2score", p2_score, 4'd1);
    tick(2);
    check("t3_collect", 4'(state), 4'd1);
    lock_both(ROCK, PAPER);
    check("t3_p2score", p2_score, 4'd2);
    tick(2);
    check("t3_mend", 4'(state), 4'd4);
    check("t3_mdone", 4'(match_done), 4'd1);
    check("t3_winner", 4'(match_winner), 4'h2);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("t3_restart", 4'(state), 4'd1);
    check("t3_p2clr", p2_score, 4'd0);
    check("t3_rcntclr", round_cnt, 4'd0);
    check("t3_winclr", 4'(match_winner), 4'h3);
    check("t3_resclr", 4'(round_result), 4'h3);
    check("t3_mdoneclr", 4'(match_done), 4'd0);

    // 4. timeouts: only p1 locked, then nobody
    p1_move = ROCK; p1_lock = 1'b1;
    tick(1);
    p1_lock = 1'b0;
    tick(6);
    check("t4_still_collect", 4'(state), 4'd1);
    tick(1);
    check("t4_judge", 4'(state), 4'd2);
    tick(1);
    check("t4_forfeit", 4'(round_result), 4'h1);
    check("t4_p1score", p1_score, 4'd1);
    tick(2);
    check("t4_collect", 4'(state), 4'd1);
    tick(8);
    check("t4_judge2", 4'(state), 4'd2);
    tick(1);
    check("t4_none", 4'(round_result), 4'h0);
    check("t4_rcnt", round_cnt, 4'd2);
    check("t4_scores", p1_score + p2_score, 4'd1);
    tick(2);

    // 5. p2 locks on the timeout cycle; p1 tries to re-lock
    check("t5_collect", 4'(state), 4'd1);
    p1_move = ROCK; p1_lock = 1'b1;
    tick(1);
    p1_lock = 1'b0;
    tick(6);
    p1_move = SCISSORS; p1_lock = 1'b1; p2_move = PAPER; p2_lock = 1'b1;
    tick(1);
    p1_lock = 1'b0; p2_lock = 1'b0;
    check("t5_judge", 4'(state), 4'd2);
    check("t5_p2locked", 4'(p2_locked), 4'd1);
    tick(1);
    check("t5_result", 4'(round_result), 4'h2);
    check("t5_p2score", p2_score, 4'd1);
    check("t5_rcnt", round_cnt, 4'd3);
    tick(2);
    check("t5_mend", 4'(state), 4'd4);
    check("t5_winner_tie", 4'(match_winner), 4'h0);

    // 6. three draws hit MAX_ROUNDS; start and 00-lock ignored in COLLECT
    start = 1'b1;
    tick(1);
    start = 1'b0;
    lock_both(PAPER, PAPER);
    check("t6_draw", 4'(round_result), 4'h0);
    tick(2);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("t6_start_ignored", 4'(state), 4'd1);
    check("t6_rcnt_kept", round_cnt, 4'd1);
    p1_move = NONE; p1_lock = 1'b1;
    tick(1);
    p1_lock = 1'b0;
    check("t6_none_lock", 4'(p1_locked), 4'd0);
    lock_both(ROCK, ROCK);
    tick(2);
    lock_both(SCISSORS, SCISSORS);
    check("t6_rcnt3", round_cnt, 4'd3);
    tick(2);
    check("t6_mend", 4'(state), 4'd4);
    check("t6_winner", 4'(match_winner), 4'h0);
    check("t6_scores", p1_score + p2_score, 4'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
